spi_master: RTL

- Initiator end of the team's SPI memory link: serializes an address/command frame onto MOSI and, on reads, deserializes MISO into a byte.
- Sits between the lab's control logic and the SPI memory responder.
- Generates SCLK and CS from the system clock; the peripheral clock and chip select are driven only by this block.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_bitclk.sv | 54 +++++
 rtl/spi_master.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants, state encoding and frame packing for the SPI memory initiator.
package spi_pkg;

  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Bit counter runs from the frame MSB index down to zero.
  localparam logic [3:0] BIT_FIRST = 4'(FRAME_BITS - 1);
  // Highest bit index that belongs to the data byte (address/rw bits sit above it).
  localparam logic [3:0] BIT_DATA_TOP = 4'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_t;

  // Frame layout: {addr, rw, data}; the data byte is zeroed on reads so the
  // responder sees a clean turnaround while it drives MISO.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [ADDR_BITS-1:0] addr,
    input logic                 rw,
    input logic [DATA_BITS-1:0] wdata
  );
    logic [DATA_BITS-1:0] data_field;
    data_field = (rw == RW_READ) ? {DATA_BITS{1'b0}} : wdata;
    return {addr, rw, data_field};
  endfunction

endpackage

// File: rtl/spi_bitclk.sv
// SCLK divider: half-period down-counter with rise/fall strobes and the sclk level.
// With i_toggle low the counter still runs, which lets the caller time a
// half-period of idle clock (the tail) without moving sclk.
module spi_bitclk #(
  parameter int CLKDIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_toggle,
  output logic o_tc,
  output logic o_rise,
  output logic o_fall,
  output logic o_sclk
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_tc;

  assign w_tc   = i_en && (r_cnt == '0);
  assign o_tc   = w_tc;
  assign o_rise = w_tc && i_toggle && !r_phase;
  assign o_fall = w_tc && i_toggle &&  r_phase;
  assign o_sclk = r_phase;

  // Half-period counter: parked at reload while disabled, wraps on terminal count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= RELOAD;
    end else if (w_tc) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // SCLK level: flips at each terminal count while toggling is allowed, low otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_phase <= 1'b0;
    end else if (w_tc && i_toggle) begin
      r_phase <= !r_phase;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI memory-link initiator: shifts a {addr, rw, data} frame out on MOSI and,
// on reads, collects the final byte from MISO into o_rdata.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_rw,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_miso,
  output logic                 o_sclk,
  output logic                 o_cs,
  output logic                 o_mosi,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DATA_BITS-1:0] o_rdata
);

  spi_state_t r_state;
  spi_state_t w_next;

  logic [FRAME_BITS-1:0] r_frame;
  logic [DATA_BITS-1:0]  r_rx;
  logic [DATA_BITS-1:0]  r_rdata;
  logic [3:0]            r_bitcnt;
  logic                  r_rw;
  logic                  r_cap_arm;

  logic w_accept;
  logic w_div_en;
  logic w_div_toggle;
  logic w_tc;
  logic w_rise;
  logic w_fall;
  logic w_data_bit;

  assign w_accept     = (r_state == ST_IDLE) && i_start;
  assign w_div_en     = (r_state == ST_SHIFT) || (r_state == ST_TAIL);
  assign w_div_toggle = (r_state == ST_SHIFT);
  assign w_data_bit   = (r_rw == RW_READ) && (r_bitcnt <= BIT_DATA_TOP);

  spi_bitclk #(
    .CLKDIV (CLKDIV)
  ) u_bitclk (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_div_en),
    .i_toggle (w_div_toggle),
    .o_tc     (w_tc),
    .o_rise   (w_rise),
    .o_fall   (w_fall),
    .o_sclk   (o_sclk)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: the last fall of bit 0 ends the shift, one divider period of tail follows.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_fall && (r_bitcnt == 4'd0)) w_next = ST_TAIL;
      ST_TAIL:  if (w_tc) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; MOSI is the frame MSB only while shifting.
  always_comb begin
    o_cs   = 1'b1;
    o_busy = 1'b0;
    o_done = 1'b0;
    o_mosi = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cs   = 1'b1;
        o_busy = 1'b0;
      end
      ST_SHIFT: begin
        o_cs   = 1'b0;
        o_busy = 1'b1;
        o_mosi = r_frame[FRAME_BITS-1];
      end
      ST_TAIL: begin
        o_cs   = 1'b0;
        o_busy = 1'b1;
      end
      ST_DONE: begin
        o_cs   = 1'b1;
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_cs   = 1'b1;
        o_busy = 1'b0;
      end
    endcase
  end

  // Frame shifter and bit counter: load on accept, advance at the end of each high half.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame  <= '0;
      r_bitcnt <= '0;
      r_rw     <= RW_WRITE;
    end else if (w_accept) begin
      r_frame  <= build_frame(i_addr, i_rw, i_wdata);
      r_bitcnt <= BIT_FIRST;
      r_rw     <= i_rw;
    end else if ((r_state == ST_SHIFT) && w_fall) begin
      r_frame <= {r_frame[FRAME_BITS-2:0], 1'b0};
      if (r_bitcnt != 4'd0) begin
        r_bitcnt <= r_bitcnt - 4'd1;
      end
    end
  end

  // Capture qualifier: armed on the rise of a read data bit so the matching fall samples MISO.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cap_arm <= 1'b0;
    end else if (r_state != ST_SHIFT) begin
      r_cap_arm <= 1'b0;
    end else if (w_rise) begin
      r_cap_arm <= w_data_bit;
    end else if (w_fall) begin
      r_cap_arm <= 1'b0;
    end
  end

  // Receive shifter: MISO sampled on the last cycle of each armed high half.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx <= '0;
    end else if (w_accept) begin
      r_rx <= '0;
    end else if (w_fall && r_cap_arm) begin
      r_rx <= {r_rx[DATA_BITS-2:0], i_miso};
    end
  end

  // Read result: published on entry to DONE so it is valid alongside the done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if ((r_state == ST_TAIL) && w_tc && (r_rw == RW_READ)) begin
      r_rdata <= r_rx;
    end
  end

  assign o_rdata = r_rdata;

endmodule
